// File: rtl/regfile_writeback_if.sv
// regfile_writeback_if
//   Bundles the write-back controller's traffic:
//   - load issue (iss_*)
//   - ALU result (alu_*)
//   - load return handshake (ld_*)
//   - register-set write port (waddr/wdata/we)
//   - decode-stage hazard query (raddr*/busy*/ld_outstanding)
//   master: the surrounding pipeline / register set. slave: regfile_writeback.
interface regfile_writeback_if;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        we;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic        busy1;
  logic        busy2;
  logic        ld_outstanding;

  modport master (
    output iss_valid, iss_rd, alu_valid, alu_rd, alu_data,
           ld_valid, ld_rd, ld_data, raddr1, raddr2,
    input  ld_ready, waddr, wdata, we, busy1, busy2, ld_outstanding
  );

  modport slave (
    input  iss_valid, iss_rd, alu_valid, alu_rd, alu_data,
           ld_valid, ld_rd, ld_data, raddr1, raddr2,
    output ld_ready, waddr, wdata, we, busy1, busy2, ld_outstanding
  );
endinterface

// File: rtl/regfile_writeback.sv
// regfile_writeback
//   Write-back controller for the 32x32 register set.
//   - Merges single-cycle ALU results with variable-latency load returns into
//     at most one registered write per cycle.
//   - ALU results always win arbitration. Loads wait in a 2-entry in-order FIFO.
//   - Keeps a per-register scoreboard of outstanding loads for decode stalls.
// Ports:
//   clk : clock, all state on posedge
//   rst : synchronous active-high reset
//   wb  : regfile_writeback_if.slave. It carries:
//         - issue, ALU and load-return inputs
//         - the registered write port waddr/wdata/we
//         - the combinational hazard outputs busy1/busy2/ld_outstanding
module regfile_writeback (
  input  logic               clk,
  input  logic               rst,
  regfile_writeback_if.slave wb
);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ld_ent_t;

  // FIFO is kept head-aligned: entry 0 is always the head, so a dequeue
  // shifts entry 1 down and an enqueue lands at the post-dequeue count.
  ld_ent_t [1:0] fifo_q, fifo_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [31:0]   pending_q, pending_d;
  logic [4:0]    waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          we_q, we_d;

  logic          ld_ready;
  logic          accept;
  logic          deq;
  logic          wr_slot;
  logic [31:0]   set_mask;
  logic [31:0]   clr_mask;

  // No dequeue credit: readiness depends only on the registered count.
  assign ld_ready = !rst && (cnt_q < 2'd2);
  assign accept   = wb.ld_valid && ld_ready;

  // The ALU cannot be stalled, so the FIFO head only drains in ALU-free cycles.
  assign deq      = !wb.alu_valid && (cnt_q != 2'd0);

  // An accept only happens with cnt_q in {0,1}.
  // The new entry goes to slot 1 only when one entry stays behind.
  assign wr_slot  = (cnt_q == 2'd1) && !deq;

  always_comb begin
    fifo_d = fifo_q;
    cnt_d  = cnt_q;
    if (deq) begin
      fifo_d[0] = fifo_q[1];
    end
    if (accept) begin
      fifo_d[wr_slot].rd   = wb.ld_rd;
      fifo_d[wr_slot].data = wb.ld_data;
    end
    cnt_d = cnt_q + {1'b0, accept} - {1'b0, deq};
  end

  // Write arbitration.
  // An idle cycle holds waddr/wdata.
  // A selected rd=0 still consumes its source but does not write.
  always_comb begin
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    clr_mask = '0;
    if (wb.alu_valid) begin
      waddr_d = wb.alu_rd;
      wdata_d = wb.alu_data;
      we_d    = (wb.alu_rd != 5'd0);
    end else if (deq) begin
      waddr_d  = fifo_q[0].rd;
      wdata_d  = fifo_q[0].data;
      we_d     = (fifo_q[0].rd != 5'd0);
      clr_mask[fifo_q[0].rd] = 1'b1;
    end
  end

  // Scoreboard.
  // - The clear is applied before the set, so a same-edge re-issue wins.
  // - Bit 0 is forced low because writes to x0 never happen.
  always_comb begin
    set_mask = '0;
    if (wb.iss_valid) begin
      set_mask[wb.iss_rd] = 1'b1;
    end
    pending_d = ((pending_q & ~clr_mask) | set_mask) & ~32'h1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_q    <= '0;
      cnt_q     <= '0;
      pending_q <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
    end else begin
      fifo_q    <= fifo_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
    end
  end

  assign wb.ld_ready       = ld_ready;
  assign wb.waddr          = waddr_q;
  assign wb.wdata          = wdata_q;
  assign wb.we             = we_q;
  assign wb.busy1          = pending_q[wb.raddr1];
  assign wb.busy2          = pending_q[wb.raddr2];
  assign wb.ld_outstanding = |pending_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback
//   Directed bench for regfile_writeback.
//   - Expected register writes are queued in launch order when stimulus is
//     issued.
//   - A negedge monitor pops the queue and compares on every we=1.
//   - Timing, hazard and handshake outputs are checked directly #1 after
//     the relevant edge.
module tb_regfile_writeback;

  logic clk;
  logic rst;
  regfile_writeback_if bus();

  regfile_writeback dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  mon_e;
  int   checks   = 0;
  int   failures = 0;

  // Issuer-side protocol tracking (loads issued but not yet returned).
  logic [31:0] iss_set;

  always @(posedge clk) begin
    if (rst) begin
      iss_set <= '0;
    end else begin
      if (bus.alu_valid)
        assert (bus.alu_rd == 5'd0 || !iss_set[bus.alu_rd])
          else $error("protocol: alu write to outstanding r%0d", bus.alu_rd);
      if (bus.ld_valid && bus.ld_ready) begin
        assert (iss_set[bus.ld_rd])
          else $error("protocol: return to non-outstanding r%0d", bus.ld_rd);
        iss_set[bus.ld_rd] <= 1'b0;
      end
      if (bus.iss_valid && bus.iss_rd != 5'd0) begin
        assert (!iss_set[bus.iss_rd])
          else $error("protocol: reissue of outstanding r%0d", bus.iss_rd);
        iss_set[bus.iss_rd] <= 1'b1;
      end
    end
  end

  // Write monitor: every launched write must match the next expected one.
  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL wr_unexpected: got r%0d=%h, required no write",
                 bus.waddr, bus.wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.waddr !== mon_e.rd || bus.wdata !== mon_e.data) begin
          failures++;
          $display("FAIL wr_order: got r%0d=%h, required r%0d=%h",
                   bus.waddr, bus.wdata, mon_e.rd, mon_e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] data);
    wr_t e;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    bus.iss_valid = 1'b0;
    bus.alu_valid = 1'b0;
    bus.ld_valid  = 1'b0;
  endtask

  initial begin
    // Reset with traffic on every input.
    rst           = 1'b1;
    bus.iss_valid = 1'b1;  bus.iss_rd   = 5'd3;
    bus.alu_valid = 1'b1;  bus.alu_rd   = 5'd5;  bus.alu_data = 32'hCAFE0000;
    bus.ld_valid  = 1'b1;  bus.ld_rd    = 5'd4;  bus.ld_data  = 32'h0BADF00D;
    bus.raddr1    = 5'd3;  bus.raddr2   = 5'd4;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("rst_we", bus.we, 0);
      chk("rst_busy1", bus.busy1, 0);
      chk("rst_busy2", bus.busy2, 0);
      chk("rst_outstanding", bus.ld_outstanding, 0);
      chk("rst_ld_ready", bus.ld_ready, 0);
    end
    rst = 1'b0;
    idle();
    #1;
    chk("post_rst_ld_ready", bus.ld_ready, 1);
    chk("post_rst_waddr", bus.waddr, 0);
    chk("post_rst_wdata", bus.wdata, 0);

    // ALU only.
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    push(5'd5, 32'hDEADBEEF);
    cyc();
    bus.alu_valid = 1'b0;
    chk("alu_we", bus.we, 1);
    chk("alu_waddr", bus.waddr, 5);
    chk("alu_wdata", bus.wdata, 32'hDEADBEEF);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h00000BAD;
    cyc();
    bus.alu_valid = 1'b0;
    chk("alu_r0_we", bus.we, 0);
    cyc();
    chk("idle_we", bus.we, 0);

    // Load round trip to r7.
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    cyc();
    bus.iss_valid = 1'b0; bus.raddr1 = 5'd7;
    #1;
    chk("ld_busy_set", bus.busy1, 1);
    chk("ld_outstanding_set", bus.ld_outstanding, 1);
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd7; bus.ld_data = 32'h00001234;
    #1;
    chk("ld_ready_empty", bus.ld_ready, 1);
    push(5'd7, 32'h00001234);
    cyc();
    bus.ld_valid = 1'b0;
    chk("ld_lat1_we", bus.we, 0);
    chk("ld_lat1_busy", bus.busy1, 1);
    cyc();
    chk("ld_lat2_we", bus.we, 1);
    chk("ld_lat2_waddr", bus.waddr, 7);
    chk("ld_lat2_busy", bus.busy1, 0);
    chk("ld_lat2_outstanding", bus.ld_outstanding, 0);

    // Priority and backpressure: loads to r3, r4, r6 under ALU traffic.
    bus.iss_valid = 1'b1;
    bus.iss_rd = 5'd3; cyc();
    bus.iss_rd = 5'd4; cyc();
    bus.iss_rd = 5'd6; cyc();
    bus.iss_valid = 1'b0;
    push(5'd10, 32'hA0000010);
    push(5'd11, 32'hA0000011);
    push(5'd12, 32'hA0000012);
    push(5'd13, 32'hA0000013);
    push(5'd3,  32'h00000333);
    push(5'd4,  32'h00000444);
    push(5'd6,  32'h00000666);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd10; bus.alu_data = 32'hA0000010;
    bus.ld_valid  = 1'b1; bus.ld_rd  = 5'd3;  bus.ld_data  = 32'h00000333;
    cyc();
    bus.alu_rd = 5'd11; bus.alu_data = 32'hA0000011;
    bus.ld_rd  = 5'd4;  bus.ld_data  = 32'h00000444;
    cyc();
    bus.alu_rd = 5'd12; bus.alu_data = 32'hA0000012;
    bus.ld_rd  = 5'd6;  bus.ld_data  = 32'h00000666;
    #1;
    chk("full_ld_ready", bus.ld_ready, 0);
    cyc();
    chk("alu_over_fifo_waddr", bus.waddr, 12);
    bus.alu_rd = 5'd13; bus.alu_data = 32'hA0000013;
    #1;
    chk("full_ld_ready_hold", bus.ld_ready, 0);
    cyc();
    chk("alu_last_waddr", bus.waddr, 13);
    bus.alu_valid = 1'b0;
    #1;
    chk("no_credit_ld_ready", bus.ld_ready, 0);
    cyc();
    bus.raddr1 = 5'd3; bus.raddr2 = 5'd4;
    #1;
    chk("drain_r3_we", bus.we, 1);
    chk("drain_r3_waddr", bus.waddr, 3);
    chk("drain_ld_ready", bus.ld_ready, 1);
    chk("drain_r3_busy", bus.busy1, 0);
    chk("drain_r4_busy", bus.busy2, 1);
    cyc();
    bus.ld_valid = 1'b0;
    chk("drain_r4_waddr", bus.waddr, 4);
    cyc();
    chk("drain_r6_waddr", bus.waddr, 6);
    cyc();
    chk("drain_done_we", bus.we, 0);
    chk("drain_outstanding", bus.ld_outstanding, 0);

    // Set/clear collision on r9.
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    cyc();
    bus.iss_valid = 1'b0;
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd9; bus.ld_data = 32'h00000999;
    push(5'd9, 32'h00000999);
    cyc();
    bus.ld_valid = 1'b0;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    cyc();
    bus.iss_valid = 1'b0; bus.raddr1 = 5'd9;
    #1;
    chk("coll_waddr", bus.waddr, 9);
    chk("coll_wdata", bus.wdata, 32'h00000999);
    chk("coll_busy", bus.busy1, 1);
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd9; bus.ld_data = 32'h00000AAA;
    push(5'd9, 32'h00000AAA);
    cyc();
    bus.ld_valid = 1'b0;
    cyc();
    chk("coll2_wdata", bus.wdata, 32'h00000AAA);
    chk("coll2_busy", bus.busy1, 0);

    // Reset mid-flight: two buffered loads, three pending bits.
    bus.iss_valid = 1'b1;
    bus.iss_rd = 5'd1; cyc();
    bus.iss_rd = 5'd2; cyc();
    bus.iss_rd = 5'd8; cyc();
    bus.iss_valid = 1'b0;
    push(5'd20, 32'h00000020);
    push(5'd21, 32'h00000021);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd20; bus.alu_data = 32'h00000020;
    bus.ld_valid  = 1'b1; bus.ld_rd  = 5'd1;  bus.ld_data  = 32'h00000011;
    cyc();
    bus.alu_rd = 5'd21; bus.alu_data = 32'h00000021;
    bus.ld_rd  = 5'd2;  bus.ld_data  = 32'h00000022;
    cyc();
    idle();
    bus.raddr1 = 5'd1; bus.raddr2 = 5'd8;
    #1;
    chk("mid_full_ld_ready", bus.ld_ready, 0);
    chk("mid_outstanding", bus.ld_outstanding, 1);
    chk("mid_busy1", bus.busy1, 1);
    chk("mid_busy2", bus.busy2, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("mid_rst_we", bus.we, 0);
    chk("mid_rst_outstanding", bus.ld_outstanding, 0);
    chk("mid_rst_busy1", bus.busy1, 0);
    chk("mid_rst_busy2", bus.busy2, 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("mid_rst_no_write", bus.we, 0);
    end
    chk("mid_rst_ld_ready", bus.ld_ready, 1);

    cyc();
    chk("exp_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
